trig_arbiter: RTL and testbench



---
 rtl/trig_pkg.sv | 19 +
 rtl/rr_pick.sv | 33 +++
 rtl/trig_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_trig_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared types and constants for the trig_arbiter block and its helpers.
package trig_pkg;

    // Arbiter FSM states; also exported on the debug port of trig_arbiter.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int DEG_FULL    = 360;
    localparam int DEG_QUARTER = 90;

    // Default angle width of a requester slice, and the fixed engine angle width.
    localparam int ANG_W_DEF = 9;
    localparam int ENG_W     = 9;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// The slot after 'last' has top priority, wrapping modulo N; emits a one-hot grant,
// the winning index, and a flag saying whether anyone was requesting at all.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Scan from last+1 upward with wrap-around and keep the first requester found.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IDX_W'((int'(last) + off) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trig_arbiter.sv
// trig_arbiter: shares one sine engine among N_REQ requesters with round-robin
// arbitration, angle reduction modulo 360 and an engine timeout.
// Optional build macro TRIG_ARB_COS_EN adds a per-requester cos_sel input that
// turns the issued angle into (90 - angle) mod 360.
//
// Handshake: a requester raises req[i] with its angle on slice i and holds both
// until ack[i] pulses for one cycle (angle captured). Exactly one rsp_valid[i]
// pulse follows later, with rsp_data and rsp_err valid in that same cycle;
// rsp_err=1 means the engine timed out and rsp_data is 0. req is only looked at
// while the arbiter is idle, so a requester may keep req high to go again.
// Engine side: eng_start pulses one cycle with eng_value; eng_done/eng_amp are
// only honoured while waiting for a result.
module trig_arbiter
    import trig_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64,
    parameter int ANG_W   = ANG_W_DEF
) (
    input  logic                   clk_100mhz,
    input  logic                   rst_in,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*ANG_W-1:0] angle,
`ifdef TRIG_ARB_COS_EN
    input  logic [N_REQ-1:0]       cos_sel,
`endif
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   eng_start,
    output logic [ENG_W-1:0]       eng_value,
    input  logic                   eng_done,
    input  logic [31:0]            eng_amp,
    output arb_state_t             dbg_state
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [IDX_W-1:0] last_q, last_nxt;
    logic [TMR_W-1:0] timer_q, timer_nxt;

    logic [N_REQ-1:0] ack_nxt;
    logic [N_REQ-1:0] rsp_valid_nxt;
    logic [31:0]      rsp_data_nxt;
    logic             rsp_err_nxt;
    logic             busy_nxt;
    logic             eng_start_nxt;
    logic [ENG_W-1:0] eng_value_nxt;

    logic [N_REQ-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic [ANG_W-1:0] sel_angle;
    logic [ANG_W-1:0] red_angle;
    logic [ENG_W-1:0] red_eng;
    logic [ENG_W-1:0] issue_value;

    assign dbg_state = state;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef TRIG_ARB_COS_EN
    localparam logic [ENG_W:0] QUARTER_W = (ENG_W + 1)'(DEG_QUARTER);
    localparam logic [ENG_W:0] WRAP_W    = (ENG_W + 1)'(DEG_FULL + DEG_QUARTER);
    logic [ENG_W:0] red_wide;
    logic [ENG_W:0] cos_wide;
`endif

    // Reduce the winner's angle into 0..359 and, if enabled, fold it into the cosine phase.
    always_comb begin
        sel_angle = angle[pick_idx*ANG_W +: ANG_W];
        red_angle = sel_angle;
        if (sel_angle >= ANG_W'(DEG_FULL)) begin
            red_angle = sel_angle - ANG_W'(DEG_FULL);
        end
        red_eng     = ENG_W'(red_angle);
        issue_value = red_eng;
`ifdef TRIG_ARB_COS_EN
        red_wide = {1'b0, red_eng};
        if (red_wide <= QUARTER_W) begin
            cos_wide = QUARTER_W - red_wide;
        end else begin
            cos_wide = WRAP_W - red_wide;
        end
        if (cos_sel[pick_idx]) begin
            issue_value = cos_wide[ENG_W-1:0];
        end
`endif
    end

    // Next-state and next-output logic; pulses default low, held values default to themselves.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx_q;
        last_nxt      = last_q;
        timer_nxt     = timer_q;
        ack_nxt       = '0;
        rsp_valid_nxt = '0;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = 1'b0;
        eng_start_nxt = 1'b0;
        eng_value_nxt = eng_value;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    idx_nxt       = pick_idx;
                    ack_nxt       = pick_grant;
                    eng_start_nxt = 1'b1;
                    eng_value_nxt = issue_value;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                timer_nxt = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    rsp_data_nxt  = eng_amp;
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = N_REQ'(1) << idx_q;
                    state_nxt     = RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    rsp_data_nxt  = '0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = N_REQ'(1) << idx_q;
                    state_nxt     = RESP;
                end else begin
                    timer_nxt = timer_q + TMR_W'(1);
                end
            end
            RESP: begin
                last_nxt  = idx_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs; reset drops any in-flight request.
    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            idx_q     <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            timer_q   <= '0;
            ack       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            eng_start <= 1'b0;
            eng_value <= '0;
        end else begin
            state     <= state_nxt;
            idx_q     <= idx_nxt;
            last_q    <= last_nxt;
            timer_q   <= timer_nxt;
            ack       <= ack_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
            busy      <= busy_nxt;
            eng_start <= eng_start_nxt;
            eng_value <= eng_value_nxt;
        end
    end

endmodule

// File: tb/tb_trig_arbiter.sv
// Bench for trig_arbiter: directed and randomized transactions checked against a
// behavioural model (modulo arithmetic for angles, wrap-around scan for grants).
module tb_trig_arbiter;
    import trig_pkg::*;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 64;
    localparam int ANG_W   = 9;

    logic                   clk_100mhz = 1'b0;
    logic                   rst_in     = 1'b1;
    logic [N_REQ-1:0]       req        = '0;
    logic [N_REQ*ANG_W-1:0] angle      = '0;
`ifdef TRIG_ARB_COS_EN
    logic [N_REQ-1:0]       cos_sel    = '0;
`endif
    logic [N_REQ-1:0]       ack;
    logic [N_REQ-1:0]       rsp_valid;
    logic [31:0]            rsp_data;
    logic                   rsp_err;
    logic                   busy;
    logic                   eng_start;
    logic [8:0]             eng_value;
    logic                   eng_done   = 1'b0;
    logic [31:0]            eng_amp    = '0;
    arb_state_t             dbg_state;

    int n_cmp  = 0;
    int n_mism = 0;

    int               m_last;
    int               angle_int [N_REQ];
    bit               cos_int   [N_REQ];
    logic [N_REQ-1:0] seen_ack;

    trig_arbiter #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT),
        .ANG_W   (ANG_W)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst_in     (rst_in),
        .req        (req),
        .angle      (angle),
`ifdef TRIG_ARB_COS_EN
        .cos_sel    (cos_sel),
`endif
        .ack        (ack),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_value  (eng_value),
        .eng_done   (eng_done),
        .eng_amp    (eng_amp),
        .dbg_state  (dbg_state)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mism++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: the angle the engine must be given for a requested angle.
    function automatic int exp_val(input int a, input bit c);
        int r;
        r = a % DEG_FULL;
        if (c) r = (DEG_QUARTER - r + DEG_FULL) % DEG_FULL;
        return r;
    endfunction

    // Model: first requester after the previous winner, wrapping around.
    function automatic int pick(input logic [N_REQ-1:0] rq, input int last);
        for (int off = 1; off <= N_REQ; off++) begin
            if (rq[(last + off) % N_REQ]) return (last + off) % N_REQ;
        end
        return 0;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input int g);
        logic [N_REQ-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    task automatic load_angles();
        for (int i = 0; i < N_REQ; i++) begin
            angle[i*ANG_W +: ANG_W] = ANG_W'(angle_int[i]);
`ifdef TRIG_ARB_COS_EN
            cos_sel[i] = cos_int[i];
`endif
        end
    endtask

    // One full transaction from the IDLE cycle: request, ack/issue, engine reply, response.
    // dly = WAIT cycle (0 = first) in which the engine answers; lat counts edges from the
    // request-sample edge to the edge that raises rsp_valid.
    task automatic do_txn(input logic [N_REQ-1:0] rq, input bit hold, input int dly,
                          input bit stale, input bit tmo, input logic [31:0] amp,
                          input string tag);
        int          g;
        int          ev;
        int          lat;
        bit          got;
        logic [31:0] exp_data;
        g  = pick(rq, m_last);
        ev = exp_val(angle_int[g], cos_int[g]);
        req = rq;
        if (stale) begin
            eng_done = 1'b1;
            eng_amp  = amp;
        end
        tick();
        seen_ack = ack;
        chk({tag, "_ack"}, 64'(ack), 64'(onehot(g)));
        chk({tag, "_start"}, 64'(eng_start), 64'(1));
        chk({tag, "_value"}, 64'(eng_value), 64'(ev));
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        if (!hold) req = '0;
        tick();
        chk({tag, "_ack_clr"}, 64'(ack), 64'(0));
        chk({tag, "_start_clr"}, 64'(eng_start), 64'(0));
        got = 1'b0;
        lat = 0;
        for (int c = 0; c < 100; c++) begin
            if (!stale) begin
                eng_done = (!tmo && c == dly);
                eng_amp  = eng_done ? amp : $urandom;
            end
            tick();
            if (rsp_valid != '0) begin
                got = 1'b1;
                lat = c + 2;
                break;
            end
        end
        eng_done = 1'b0;
        exp_data = tmo ? 32'h0 : amp;
        chk({tag, "_rsp_seen"}, 64'(got), 64'(1));
        chk({tag, "_latency"}, 64'(lat), 64'(tmo ? TIMEOUT + 1 : (stale ? 2 : dly + 2)));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(onehot(g)));
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_data));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(tmo));
        chk({tag, "_ack_in_rsp"}, 64'(ack), 64'(0));
        m_last = g;
        tick();
        chk({tag, "_rsp_clr"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_data_hold"}, 64'(rsp_data), 64'(exp_data));
        chk({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 64'(ack), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_start"}, 64'(eng_start), 64'(0));
        chk({tag, "_value"}, 64'(eng_value), 64'(0));
        chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    initial begin
        int rr_exp [5];
        rr_exp = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N_REQ; i++) begin
            angle_int[i] = 0;
            cos_int[i]   = 1'b0;
        end
        load_angles();

        // Reset state.
        tick();
        tick();
        chk_all_zero("reset");
        rst_in = 1'b0;
        m_last = N_REQ - 1;
        tick();
        chk_all_zero("post_reset");

        // Round-robin with every requester holding req: 0,1,2,3,0.
        for (int i = 0; i < N_REQ; i++) angle_int[i] = 40 * i + 10;
        load_angles();
        for (int i = 0; i < 5; i++) begin
            do_txn('1, 1'b1, 1, 1'b0, 1'b0, 32'h1000 + 32'(i), "rr");
            chk("rr_order", 64'(seen_ack), 64'(onehot(rr_exp[i])));
        end
        req = '0;
        tick();

        // Single requester, engine answers 3 cycles after the start pulse.
        angle_int[0] = 30;
        load_angles();
        do_txn(4'b0001, 1'b0, 2, 1'b0, 1'b0, 32'h0000_8000, "single");

        // Angle wrap boundaries.
        angle_int[0] = 450; load_angles();
        do_txn(4'b0001, 1'b0, 0, 1'b0, 1'b0, 32'h0000_0450, "wrap450");
        chk("wrap450_lit", 64'(exp_val(450, 1'b0)), 64'(90));
        angle_int[0] = 360; load_angles();
        do_txn(4'b0001, 1'b0, 0, 1'b0, 1'b0, 32'h0000_0360, "wrap360");
        angle_int[0] = 359; load_angles();
        do_txn(4'b0001, 1'b0, 0, 1'b0, 1'b0, 32'h0000_0359, "wrap359");

        // Engine never answers, then a normal request afterwards.
        angle_int[2] = 123; load_angles();
        do_txn(4'b0100, 1'b0, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, "timeout");
        angle_int[3] = 77; load_angles();
        do_txn(4'b1000, 1'b0, 1, 1'b0, 1'b0, 32'h1234_5678, "after_tmo");

        // Stale done held high through IDLE and ISSUE.
        eng_done = 1'b1;
        eng_amp  = 32'hFFFF_0000;
        tick();
        chk("stale_idle_busy", 64'(busy), 64'(0));
        chk("stale_idle_rsp", 64'(rsp_valid), 64'(0));
        angle_int[1] = 200; load_angles();
        do_txn(4'b0010, 1'b0, 0, 1'b1, 1'b0, 32'hFFFF_0000, "stale");

        // Asynchronous reset while waiting on the engine.
        angle_int[0] = 100; load_angles();
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        tick();
        tick();
        chk("midwait_busy", 64'(busy), 64'(1));
        #2;
        rst_in = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        chk("rst_hold_rsp", 64'(rsp_valid), 64'(0));
        rst_in = 1'b0;
        m_last = N_REQ - 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("after_rst_rsp", 64'(rsp_valid), 64'(0));
            chk("after_rst_ack", 64'(ack), 64'(0));
        end
        angle_int[1] = 45; load_angles();
        do_txn(4'b0010, 1'b0, 0, 1'b0, 1'b0, 32'h0BAD_F00D, "post_rst");

        // Pointer reset: with 0 and 1 both requesting, 0 wins first after reset.
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        m_last = N_REQ - 1;
        tick();
        do_txn(4'b0011, 1'b0, 0, 1'b0, 1'b0, 32'h0000_0011, "ptr_rst");

`ifdef TRIG_ARB_COS_EN
        angle_int[0] = 200; cos_int[0] = 1'b1; load_angles();
        do_txn(4'b0001, 1'b0, 0, 1'b0, 1'b0, 32'h0000_0250, "cos200");
        chk("cos200_lit", 64'(exp_val(200, 1'b1)), 64'(250));
        angle_int[0] = 0; load_angles();
        do_txn(4'b0001, 1'b0, 0, 1'b0, 1'b0, 32'h0000_0090, "cos0");
        cos_int[0] = 1'b0;
`endif

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N_REQ; i++) begin
                angle_int[i] = $urandom_range(0, 511);
`ifdef TRIG_ARB_COS_EN
                cos_int[i] = 1'($urandom_range(0, 1));
`endif
            end
            load_angles();
            do_txn(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 5), 1'b0, 1'b0, $urandom, "rand");
            req = '0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
